// File: rtl/ysram_access_sched_pkg.sv
// Shared types and constants for the Y SRAM access scheduler.
// Holds the scheduler state enum, the owner encoding, the Y SRAM address/row
// widths and the default park address driven on idle SRAM ports.
package ysram_access_sched_pkg;

  localparam int YADDR_W = 11;
  localparam int YROW_W  = 256;
  localparam int WDOG_W  = 16;
  localparam int UPD_W   = 16;

  localparam logic [YADDR_W-1:0] PARK_ADDR_DEF = 11'h7ff;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CP_GNT  = 2'd1,
    ST_WP_GNT  = 2'd2,
    ST_RELEASE = 2'd3
  } sched_state_e;

  // Identifies which path held the SRAM most recently (fairness tie-break).
  typedef enum logic {
    OWN_CP = 1'b0,
    OWN_WP = 1'b1
  } owner_e;

endpackage

// File: rtl/ysram_access_sched_mux.sv
// Purpose: combinational Y SRAM port mux selected by the scheduler state.
// Ports  : i_state selects; cp read addresses, wp read/write signals in;
//          SRAM read addresses, write enable/address/row out.
// Un-owned ports are parked at PARK_ADDR with write disabled and zero data.
module ysram_mux
  import ysram_access_sched_pkg::*;
#(
  parameter logic [YADDR_W-1:0] PARK_ADDR = PARK_ADDR_DEF
) (
  input  sched_state_e        i_state,
  input  logic [YADDR_W-1:0]  i_cp_rd_addr1,
  input  logic [YADDR_W-1:0]  i_cp_rd_addr2,
  input  logic [YADDR_W-1:0]  i_wp_rd_addr1,
  input  logic [YADDR_W-1:0]  i_wp_rd_addr2,
  input  logic                i_wp_we,
  input  logic [YADDR_W-1:0]  i_wp_wr_addr,
  input  logic [YROW_W-1:0]   i_wp_wr_data,
  output logic [YADDR_W-1:0]  o_sram_rd_addr1,
  output logic [YADDR_W-1:0]  o_sram_rd_addr2,
  output logic                o_sram_we,
  output logic [YADDR_W-1:0]  o_sram_wr_addr,
  output logic [YROW_W-1:0]   o_sram_wr_data
);

  always_comb begin
    o_sram_rd_addr1 = PARK_ADDR;
    o_sram_rd_addr2 = PARK_ADDR;
    o_sram_we       = 1'b0;
    o_sram_wr_addr  = PARK_ADDR;
    o_sram_wr_data  = '0;
    case (i_state)
      ST_CP_GNT: begin
        // Compute path only reads; write port stays parked.
        o_sram_rd_addr1 = i_cp_rd_addr1;
        o_sram_rd_addr2 = i_cp_rd_addr2;
      end
      ST_WP_GNT: begin
        o_sram_rd_addr1 = i_wp_rd_addr1;
        o_sram_rd_addr2 = i_wp_rd_addr2;
        o_sram_we       = i_wp_we;
        o_sram_wr_addr  = i_wp_wr_addr;
        o_sram_wr_data  = i_wp_wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysram_access_sched.sv
// Purpose: arbitrates Y SRAM ownership between compute and write-back paths.
// Ports  : cp/wp req+done handshakes and SRAM-side signals in; registered
//          grants, muxed SRAM ports, busy, write-back count, sticky timeout out.
// Grant follows req by one cycle; a RELEASE dead cycle separates owners; a
// watchdog forces release after TIMEOUT_CYCLES grant cycles without done.
module ysram_access_sched
  import ysram_access_sched_pkg::*;
#(
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter logic [YADDR_W-1:0]  PARK_ADDR      = PARK_ADDR_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cp_req,
  input  logic                i_cp_done,
  input  logic [YADDR_W-1:0]  i_cp_rd_addr1,
  input  logic [YADDR_W-1:0]  i_cp_rd_addr2,
  input  logic                i_wp_req,
  input  logic                i_wp_done,
  input  logic [YADDR_W-1:0]  i_wp_rd_addr1,
  input  logic [YADDR_W-1:0]  i_wp_rd_addr2,
  input  logic                i_wp_we,
  input  logic [YADDR_W-1:0]  i_wp_wr_addr,
  input  logic [YROW_W-1:0]   i_wp_wr_data,
  output logic                o_cp_grant,
  output logic                o_wp_grant,
  output logic [YADDR_W-1:0]  o_sram_rd_addr1,
  output logic [YADDR_W-1:0]  o_sram_rd_addr2,
  output logic                o_sram_we,
  output logic [YADDR_W-1:0]  o_sram_wr_addr,
  output logic [YROW_W-1:0]   o_sram_wr_data,
  output logic                o_sched_busy,
  output logic [UPD_W-1:0]    o_upd_count,
  output logic                o_timeout_err
);

  // Watchdog value seen on the last permitted grant cycle.
  localparam logic [WDOG_W-1:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  sched_state_e        r_state;
  owner_e              r_last_owner;
  logic [WDOG_W-1:0]   r_wdog;
  logic [UPD_W-1:0]    r_upd_count;
  logic                r_timeout_err;
  logic                r_cp_grant;
  logic                r_wp_grant;

  sched_state_e        w_state_nxt;
  owner_e              w_last_owner_nxt;
  logic                w_wdog_expired;
  logic                w_force_release;
  logic                w_upd_inc;
  logic                w_in_gnt;

  assign w_wdog_expired = (r_wdog == WDOG_LAST);
  assign w_in_gnt       = (r_state == ST_CP_GNT) || (r_state == ST_WP_GNT);

  // Next-state logic. Only the owner's done is looked at; a done that
  // coincides with watchdog expiry wins and counts as a normal completion.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_force_release  = 1'b0;
    w_upd_inc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cp_req && i_wp_req) begin
          w_state_nxt = (r_last_owner == OWN_WP) ? ST_CP_GNT : ST_WP_GNT;
        end else if (i_cp_req) begin
          w_state_nxt = ST_CP_GNT;
        end else if (i_wp_req) begin
          w_state_nxt = ST_WP_GNT;
        end
      end
      ST_CP_GNT: begin
        if (i_cp_done) begin
          w_state_nxt      = ST_RELEASE;
          w_last_owner_nxt = OWN_CP;
        end else if (w_wdog_expired) begin
          w_state_nxt      = ST_RELEASE;
          w_last_owner_nxt = OWN_CP;
          w_force_release  = 1'b1;
        end
      end
      ST_WP_GNT: begin
        if (i_wp_done) begin
          w_state_nxt      = ST_RELEASE;
          w_last_owner_nxt = OWN_WP;
          w_upd_inc        = 1'b1;
        end else if (w_wdog_expired) begin
          w_state_nxt      = ST_RELEASE;
          w_last_owner_nxt = OWN_WP;
          w_force_release  = 1'b1;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_last_owner  <= OWN_WP;
      r_wdog        <= '0;
      r_upd_count   <= '0;
      r_timeout_err <= 1'b0;
      r_cp_grant    <= 1'b0;
      r_wp_grant    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      // Counts only while the same grant persists; any entry starts at zero.
      if (w_in_gnt && (w_state_nxt == r_state)) begin
        r_wdog <= r_wdog + 1'b1;
      end else begin
        r_wdog <= '0;
      end
      if (w_upd_inc) begin
        r_upd_count <= r_upd_count + 1'b1;
      end
      if (w_force_release) begin
        r_timeout_err <= 1'b1;
      end
      // Grants are flops loaded from the next state so they track r_state.
      r_cp_grant <= (w_state_nxt == ST_CP_GNT);
      r_wp_grant <= (w_state_nxt == ST_WP_GNT);
    end
  end

  assign o_cp_grant    = r_cp_grant;
  assign o_wp_grant    = r_wp_grant;
  assign o_sched_busy  = (r_state != ST_IDLE);
  assign o_upd_count   = r_upd_count;
  assign o_timeout_err = r_timeout_err;

  ysram_mux #(
    .PARK_ADDR (PARK_ADDR)
  ) u_mux (
    .i_state         (r_state),
    .i_cp_rd_addr1   (i_cp_rd_addr1),
    .i_cp_rd_addr2   (i_cp_rd_addr2),
    .i_wp_rd_addr1   (i_wp_rd_addr1),
    .i_wp_rd_addr2   (i_wp_rd_addr2),
    .i_wp_we         (i_wp_we),
    .i_wp_wr_addr    (i_wp_wr_addr),
    .i_wp_wr_data    (i_wp_wr_data),
    .o_sram_rd_addr1 (o_sram_rd_addr1),
    .o_sram_rd_addr2 (o_sram_rd_addr2),
    .o_sram_we       (o_sram_we),
    .o_sram_wr_addr  (o_sram_wr_addr),
    .o_sram_wr_data  (o_sram_wr_data)
  );

endmodule

// File: tb/tb_ysram_access_sched.sv
// Bench for ysram_access_sched: directed scenarios plus randomized rounds
// checked against a transaction-level model of the arbitration rules.
module tb_ysram_access_sched;

  localparam int TMO = 8;
  localparam logic [10:0] PARK = 11'h7ff;

  typedef struct packed {
    logic [10:0]  rd1;
    logic [10:0]  rd2;
    logic         we;
    logic [10:0]  wa;
    logic [255:0] wd;
  } mux_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cp_req, cp_done, wp_req, wp_done, wp_we;
  logic [10:0]  cp_rd1, cp_rd2, wp_rd1, wp_rd2, wp_wa;
  logic [255:0] wp_wd;
  logic         o_cp_grant, o_wp_grant, o_sram_we, o_sched_busy, o_timeout_err;
  logic [10:0]  o_sram_rd_addr1, o_sram_rd_addr2, o_sram_wr_addr;
  logic [255:0] o_sram_wr_data;
  logic [15:0]  o_upd_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int exp_upd     = 0;
  bit exp_terr    = 1'b0;
  bit exp_last_wp = 1'b1;

  always #5 clk = ~clk;

  ysram_access_sched #(
    .TIMEOUT_CYCLES (TMO),
    .PARK_ADDR      (PARK)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_cp_req        (cp_req),
    .i_cp_done       (cp_done),
    .i_cp_rd_addr1   (cp_rd1),
    .i_cp_rd_addr2   (cp_rd2),
    .i_wp_req        (wp_req),
    .i_wp_done       (wp_done),
    .i_wp_rd_addr1   (wp_rd1),
    .i_wp_rd_addr2   (wp_rd2),
    .i_wp_we         (wp_we),
    .i_wp_wr_addr    (wp_wa),
    .i_wp_wr_data    (wp_wd),
    .o_cp_grant      (o_cp_grant),
    .o_wp_grant      (o_wp_grant),
    .o_sram_rd_addr1 (o_sram_rd_addr1),
    .o_sram_rd_addr2 (o_sram_rd_addr2),
    .o_sram_we       (o_sram_we),
    .o_sram_wr_addr  (o_sram_wr_addr),
    .o_sram_wr_data  (o_sram_wr_data),
    .o_sched_busy    (o_sched_busy),
    .o_upd_count     (o_upd_count),
    .o_timeout_err   (o_timeout_err)
  );

  // Expected SRAM port values for an owner (0 none, 1 cp, 2 wp).
  function automatic mux_t exp_mux(input int own);
    mux_t m;
    m.rd1 = PARK; m.rd2 = PARK; m.we = 1'b0; m.wa = PARK; m.wd = '0;
    if (own == 1) begin
      m.rd1 = cp_rd1; m.rd2 = cp_rd2;
    end else if (own == 2) begin
      m.rd1 = wp_rd1; m.rd2 = wp_rd2; m.we = wp_we; m.wa = wp_wa; m.wd = wp_wd;
    end
    return m;
  endfunction

  function automatic mux_t act_mux();
    mux_t m;
    m = {o_sram_rd_addr1, o_sram_rd_addr2, o_sram_we, o_sram_wr_addr, o_sram_wr_data};
    return m;
  endfunction

  task automatic drive_data(input bit fixed);
    cp_rd1 = 11'($urandom); cp_rd2 = 11'($urandom);
    wp_rd1 = 11'($urandom); wp_rd2 = 11'($urandom);
    wp_we  = 1'($urandom);  wp_wa  = 11'($urandom);
    wp_wd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (fixed) begin
      wp_we = 1'b1; wp_wa = 11'h012; wp_wd = {32{8'hA5}};
    end
  endtask

  // One request round entered and left in IDLE at a falling edge.
  // len = grant cycle on which the owner pulses done (> TMO means never).
  task automatic do_round(input bit cp, input bit wp, input int len, input bit drop,
                          input bit noise, input bit fixed, input string tag);
    int own; int glen; bit tmo; logic [1:0] exp_g; mux_t em; mux_t am;
    if (cp && wp) own = exp_last_wp ? 1 : 2;
    else          own = cp ? 1 : 2;
    glen  = (len <= TMO) ? len : TMO;
    tmo   = (len > TMO);
    exp_g = (own == 1) ? 2'b10 : 2'b01;
    cp_req = cp; wp_req = wp; drive_data(fixed);
    for (int k = 1; k <= glen; k++) begin
      @(negedge clk);
      n_tests++;
      if ({o_cp_grant, o_wp_grant} !== exp_g || o_sched_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s grant cyc %0d: grants=%b busy=%b, expected grants=%b busy=1",
                 tag, k, {o_cp_grant, o_wp_grant}, o_sched_busy, exp_g);
      end
      em = exp_mux(own); am = act_mux();
      n_tests++;
      if (am !== em) begin
        n_fail++;
        $display("FAIL %s mux cyc %0d: got %h, expected %h", tag, k, am, em);
      end
      cp_done = (own == 1) ? (k == len) : (noise && (k % 2 == 1));
      wp_done = (own == 2) ? (k == len) : (noise && (k % 2 == 1));
      if (drop && k == 1) begin
        if (own == 1) cp_req = 1'b0; else wp_req = 1'b0;
      end
      drive_data(fixed);
    end
    @(negedge clk);
    exp_last_wp = (own == 2);
    if (tmo) exp_terr = 1'b1;
    else if (own == 2) exp_upd = (exp_upd + 1) % 65536;
    em = exp_mux(0); am = act_mux();
    n_tests++;
    if ({o_cp_grant, o_wp_grant} !== 2'b00 || o_sched_busy !== 1'b1 || am !== em) begin
      n_fail++;
      $display("FAIL %s release: grants=%b busy=%b mux=%h, expected grants=00 busy=1 mux=%h",
               tag, {o_cp_grant, o_wp_grant}, o_sched_busy, am, em);
    end
    n_tests++;
    if (o_upd_count !== 16'(exp_upd) || o_timeout_err !== exp_terr) begin
      n_fail++;
      $display("FAIL %s counters: upd=%0d terr=%b, expected upd=%0d terr=%b",
               tag, o_upd_count, o_timeout_err, exp_upd, exp_terr);
    end
    cp_req = 1'b0; wp_req = 1'b0; cp_done = 1'b0; wp_done = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_sched_busy !== 1'b0 || {o_cp_grant, o_wp_grant} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b grants=%b, expected busy=0 grants=00",
               tag, o_sched_busy, {o_cp_grant, o_wp_grant});
    end
  endtask

  task automatic test_reset();
    mux_t em; mux_t am;
    @(negedge clk);
    em = exp_mux(0); am = act_mux();
    n_tests++;
    if ({o_cp_grant, o_wp_grant, o_sched_busy, o_timeout_err} !== 4'b0000 ||
        o_upd_count !== 16'd0 || am !== em) begin
      n_fail++;
      $display("FAIL reset_state: g=%b busy=%b terr=%b upd=%0d mux=%h, expected zeros and mux=%h",
               {o_cp_grant, o_wp_grant}, o_sched_busy, o_timeout_err, o_upd_count, am, em);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_sched_busy !== 1'b0 || {o_cp_grant, o_wp_grant} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b grants=%b, expected 0/00", o_sched_busy, {o_cp_grant, o_wp_grant});
    end
  endtask

  // Both requests held from reset: expect CP, WP, CP, WP with RELEASE+IDLE gaps.
  task automatic test_alternate();
    int gap; int own;
    cp_req = 1'b1; wp_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      gap = 0;
      @(negedge clk);
      cp_done = 1'b0; wp_done = 1'b0;
      while (!(o_cp_grant || o_wp_grant) && gap < 6) begin
        gap++;
        @(negedge clk);
      end
      own = o_cp_grant ? 1 : (o_wp_grant ? 2 : 0);
      n_tests++;
      if (own !== ((n % 2 == 0) ? 1 : 2) || gap !== ((n == 0) ? 0 : 2)) begin
        n_fail++;
        $display("FAIL alternate #%0d: owner=%0d gap=%0d, expected owner=%0d gap=%0d",
                 n, own, gap, (n % 2 == 0) ? 1 : 2, (n == 0) ? 0 : 2);
      end
      for (int k = 2; k <= 3; k++) @(negedge clk);
      if (own == 1) cp_done = 1'b1; else wp_done = 1'b1;
    end
    @(negedge clk);
    cp_done = 1'b0; wp_done = 1'b0; cp_req = 1'b0; wp_req = 1'b0;
    @(negedge clk);
    exp_last_wp = 1'b1;
    exp_upd += 2;
    n_tests++;
    if (o_upd_count !== 16'(exp_upd)) begin
      n_fail++;
      $display("FAIL alternate_upd: upd=%0d, expected %0d", o_upd_count, exp_upd);
    end
  endtask

  task automatic test_cp_only();
    do_round(1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, "cp_only");
  endtask

  task automatic test_wp_write();
    do_round(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, "wp_write");
  endtask

  task automatic test_ignore_cp_done();
    do_round(1'b0, 1'b1, 6, 1'b1, 1'b1, 1'b0, "ignore_cp_done");
  endtask

  // CP holds the SRAM with no done; WP waits and must win right after.
  task automatic test_timeout();
    int cnt;
    cp_req = 1'b1; drive_data(1'b0);
    @(negedge clk);
    cnt = 0;
    while (o_cp_grant === 1'b1 && cnt < 20) begin
      cnt++;
      wp_req = 1'b1;
      @(negedge clk);
    end
    exp_terr = 1'b1;
    n_tests++;
    if (cnt !== TMO || o_timeout_err !== 1'b1 || o_wp_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: grant_cycles=%0d terr=%b wp_g=%b, expected %0d/1/0",
               cnt, o_timeout_err, o_wp_grant, TMO);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({o_cp_grant, o_wp_grant} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_next: grants=%b, expected 01", {o_cp_grant, o_wp_grant});
    end
    wp_done = 1'b1; cp_req = 1'b0;
    @(negedge clk);
    wp_done = 1'b0; wp_req = 1'b0;
    exp_upd++; exp_last_wp = 1'b1;
    n_tests++;
    if (o_upd_count !== 16'(exp_upd) || o_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_after: upd=%0d terr=%b, expected %0d/1", o_upd_count, o_timeout_err, exp_upd);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int pat;
    for (int r = 0; r < 40; r++) begin
      pat = $urandom_range(1, 3);
      do_round(pat[0], pat[1], $urandom_range(1, TMO + 3), 1'($urandom),
               1'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_wp();
    mux_t em; mux_t am;
    wp_req = 1'b1; drive_data(1'b1);
    @(negedge clk);
    n_tests++;
    if (o_wp_grant !== 1'b1 || o_sram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: wp_g=%b we=%b, expected 1/1", o_wp_grant, o_sram_we);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_upd = 0; exp_terr = 1'b0; exp_last_wp = 1'b1;
    em = exp_mux(0); am = act_mux();
    n_tests++;
    if ({o_cp_grant, o_wp_grant, o_sched_busy, o_timeout_err} !== 4'b0000 ||
        o_upd_count !== 16'd0 || am !== em) begin
      n_fail++;
      $display("FAIL rst_mid: g=%b busy=%b terr=%b upd=%0d mux=%h, expected zeros and mux=%h",
               {o_cp_grant, o_wp_grant}, o_sched_busy, o_timeout_err, o_upd_count, am, em);
    end
    @(negedge clk);
    n_tests++;
    if (o_sram_we !== 1'b0 || o_wp_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: we=%b wp_g=%b, expected 0/0", o_sram_we, o_wp_grant);
    end
    cp_req = 1'b1; wp_req = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({o_cp_grant, o_wp_grant} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_restart: grants=%b, expected 10", {o_cp_grant, o_wp_grant});
    end
    cp_done = 1'b1; wp_req = 1'b0;
    @(negedge clk);
    cp_done = 1'b0; cp_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    cp_req = 1'b0; cp_done = 1'b0; wp_req = 1'b0; wp_done = 1'b0;
    drive_data(1'b0);
    test_reset();
    test_alternate();
    test_cp_only();
    test_wp_write();
    test_ignore_cp_done();
    test_timeout();
    test_random();
    test_reset_mid_wp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
